// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg: shared widths and opcode encodings for the datapath ALU.
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB = 5'd1;
  localparam logic [OP_W-1:0] OP_AND = 5'd2;
  localparam logic [OP_W-1:0] OP_OR  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL = 5'd4;
  localparam logic [OP_W-1:0] OP_SRA = 5'd5;
  localparam logic [OP_W-1:0] OP_ROR = 5'd6;

endpackage

`default_nettype wire

// File: rtl/alu_adder.sv
// ============================================================================
// alu_adder: 32-bit adder with carry-in, producing sum and signed overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_adder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  assign sum = a + b + {{(DATA_W-1){1'b0}}, cin};

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// alu_core: registered 32-bit ALU (add/sub/and/or/sll/sra, branch flags).
// Build macro ALU_ROTATE_EN turns opcode 6 into rotate-right.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [OP_W-1:0]   ctrl_ALUopcode,
  input  logic [4:0]        ctrl_shiftamt,
  output logic [DATA_W-1:0] data_result,
  output logic              isNotEqual,
  output logic              isLessThan,
  output logic              overflow
);

  logic              is_sub;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;
  logic [DATA_W-1:0] ror_res;

  logic [DATA_W-1:0] result_d;
  logic              ne_d;
  logic              lt_d;
  logic              ovf_d;

  // Subtraction is A + ~B + 1 through the shared adder.
  assign is_sub = (ctrl_ALUopcode == OP_SUB);
  assign add_b  = is_sub ? ~data_operandB : data_operandB;

  alu_adder u_adder (
    .a   (data_operandA),
    .b   (add_b),
    .cin (is_sub),
    .sum (add_sum),
    .ovf (add_ovf)
  );

`ifdef ALU_ROTATE_EN
  // A 32-bit left shift by 32 yields zero, so shiftamt 0 returns A unchanged.
  assign ror_res = (data_operandA >> ctrl_shiftamt)
                 | (data_operandA << (6'd32 - {1'b0, ctrl_shiftamt}));
`else
  assign ror_res = '0;
`endif

  always_comb begin
    result_d = '0;
    ne_d     = 1'b0;
    lt_d     = 1'b0;
    ovf_d    = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        result_d = add_sum;
        ovf_d    = add_ovf;
      end
      OP_SUB: begin
        result_d = add_sum;
        ovf_d    = add_ovf;
        ne_d     = (data_operandA != data_operandB);
        lt_d     = add_sum[DATA_W-1] ^ add_ovf;
      end
      OP_AND:  result_d = data_operandA & data_operandB;
      OP_OR:   result_d = data_operandA | data_operandB;
      OP_SLL:  result_d = data_operandA << ctrl_shiftamt;
      OP_SRA:  result_d = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
      OP_ROR:  result_d = ror_res;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_result <= '0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      data_result <= result_d;
      isNotEqual  <= ne_d;
      isLessThan  <= lt_d;
      overflow    <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// tb_alu_core: directed self-checking bench for alu_core (ALU_ROTATE_EN aware).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_core;

  logic        clock;
  logic        resetn;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;

  int tests;
  int fails;

  alu_core dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares {result, ne, lt, ovf} against the hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] res,
                       input logic ne, input logic lt, input logic ovf);
    logic [34:0] obs;
    logic [34:0] exp;
    obs = {data_result, isNotEqual, isLessThan, overflow};
    exp = {res, ne, lt, ovf};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed res=%h ne=%b lt=%b ovf=%b, expected res=%h ne=%b lt=%b ovf=%b",
             tag, obs[34:3], obs[2], obs[1], obs[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drives one operation at the falling edge; returns at the next falling edge.
  task automatic apply(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    ctrl_ALUopcode = op;
    data_operandA  = a;
    data_operandB  = b;
    ctrl_shiftamt  = sh;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    resetn         = 1'b0;
    data_operandA  = 32'h1234_5678;
    data_operandB  = 32'h0000_0001;
    ctrl_ALUopcode = 5'd1;
    ctrl_shiftamt  = 5'd0;

    repeat (2) @(negedge clock);
    check("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    apply(5'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd7);
    check("or", 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0);

    apply(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    check("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    apply(5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 5'd31);
    check("add_plain", 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    apply(5'd1, 32'hFFFF_FFFB, 32'h0000_0003, 5'd0);
    check("sub_neg", 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);

    apply(5'd1, 32'h0000_0007, 32'h0000_0007, 5'd0);
    check("sub_equal", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    apply(5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0);
    check("sub_ovf_lt", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);

    apply(5'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("sub_ovf_ge", 32'h8000_0000, 1'b1, 1'b0, 1'b1);

    apply(5'd9, 32'hDEAD_BEEF, 32'h0000_0001, 5'd3);
    check("unused_op9", 32'h0, 1'b0, 1'b0, 1'b0);

    apply(5'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4);
    check("and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);

    apply(5'd5, 32'h8000_0010, 32'hFFFF_FFFF, 5'd4);
    check("sra", 32'hF800_0001, 1'b0, 1'b0, 1'b0);

    apply(5'd4, 32'h0000_0001, 32'h1234_5678, 5'd31);
    check("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    apply(5'd5, 32'h4000_0000, 32'h0, 5'd30);
    check("sra_pos", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

`ifdef ALU_ROTATE_EN
    apply(5'd6, 32'h0000_0001, 32'h0, 5'd1);
    check("ror1", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    apply(5'd6, 32'hA5A5_0F0F, 32'h0, 5'd0);
    check("ror0", 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0);
`else
    apply(5'd6, 32'h0000_0001, 32'h0, 5'd1);
    check("op6_unused", 32'h0, 1'b0, 1'b0, 1'b0);
`endif

    // Outputs must hold while inputs wiggle between edges.
    apply(5'd1, 32'hFFFF_FFFB, 32'h0000_0003, 5'd0);
    data_operandA  = 32'h0000_0000;
    data_operandB  = 32'h0000_0000;
    ctrl_ALUopcode = 5'd3;
    #2;
    check("hold_between_edges", 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with nonzero outputs pending.
    apply(5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0);
    #1 resetn = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    apply(5'd3, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    check("after_reset", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
